// File: rtl/clint_axi_lite_pkg.sv
// clint_axi_lite_pkg: shared register offsets, response codes and state encodings for the CLINT
package clint_axi_lite_pkg;
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_e;
  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    for (int i = 0; i < 8; i++) strb_mask[i*8 +: 8] = {8{strb[i]}};
  endfunction
endpackage

// File: rtl/clint_axi_lite_timer.sv
// clint_timer: prescaled mtime counter, mtimecmp register and registered timer compare
module clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_we,
  input  logic        cmp_we,
  input  logic [63:0] wmask,
  input  logic [63:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic mtip_q, mtip_d, tick;
  always_comb begin
    tick = pre_q == PW'(TICK_DIV - 1);
    pre_d = tick ? '0 : pre_q + PW'(1);
    mtime_d = time_we ? (mtime_q & ~wmask) | (wdata & wmask) : mtime_q + {63'd0, tick};
    cmp_d = cmp_we ? (cmp_q & ~wmask) | (wdata & wmask) : cmp_q;
    mtip_d = mtime_q >= cmp_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
      mtime_q <= '0;
      cmp_q <= '1;
      mtip_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      mtip_q <= mtip_d;
    end
  end
  assign mtime = mtime_q;
  assign mtimecmp = cmp_q;
  assign mtip = mtip_q;
endmodule

// File: rtl/clint_axi_lite.sv
// clint_axi_lite: AXI4-Lite responder for msip, mtimecmp and mtime with interrupt outputs
module clint_axi_lite import clint_axi_lite_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] BASE     = 'h0200_0000,
  parameter int                TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                clint_mtip,
  output logic                clint_msip
);
  function automatic sel_e decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    decode = off == ADDR_W'(CLINT_MSIP) ? SEL_MSIP :
             off == ADDR_W'(CLINT_MTIMECMP) ? SEL_MTIMECMP :
             off == ADDR_W'(CLINT_MTIME) ? SEL_MTIME : SEL_NONE;
  endfunction
  r_state_e r_q, r_d;
  w_state_e w_q, w_d;
  logic [63:0] rdata_q, rdata_d, wdata_q, wdata_d, wmask, mtime, mtimecmp;
  logic [1:0] rresp_q, rresp_d, bresp_q, bresp_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [7:0] wstrb_q, wstrb_d;
  logic aw_q, aw_d, wh_q, wh_d, msip_q, msip_d, cmsip_q;
  logic ar_hs, aw_hs, w_hs, commit, time_we, cmp_we;
  sel_e rsel, wsel;
  assign ARREADY = r_q == R_IDLE;
  assign RVALID = r_q == R_RESP;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign AWREADY = w_q == W_IDLE && !aw_q;
  assign WREADY = w_q == W_IDLE && !wh_q;
  assign BVALID = w_q == W_RESP;
  assign BRESP = bresp_q;
  assign clint_msip = cmsip_q;
  always_comb begin
    ar_hs = ARVALID && ARREADY;
    rsel = decode(ARADDR);
    r_d = ar_hs ? R_RESP : (r_q == R_RESP && RREADY) ? R_IDLE : r_q;
    rdata_d = !ar_hs ? rdata_q :
              rsel == SEL_MSIP ? {63'd0, msip_q} :
              rsel == SEL_MTIMECMP ? mtimecmp :
              rsel == SEL_MTIME ? mtime : '0;
    rresp_d = !ar_hs ? rresp_q : rsel == SEL_NONE ? RESP_SLVERR : RESP_OKAY;
    aw_hs = AWVALID && AWREADY;
    w_hs = WVALID && WREADY;
    commit = w_q == W_IDLE && (aw_q || aw_hs) && (wh_q || w_hs);
    aw_d = !commit && (aw_q || aw_hs);
    wh_d = !commit && (wh_q || w_hs);
    awaddr_d = aw_hs ? AWADDR : awaddr_q;
    wdata_d = w_hs ? WDATA : wdata_q;
    wstrb_d = w_hs ? WSTRB : wstrb_q;
    wsel = decode(awaddr_d);
    wmask = strb_mask(wstrb_d);
    w_d = commit ? W_RESP : (w_q == W_RESP && BREADY) ? W_IDLE : w_q;
    bresp_d = !commit ? bresp_q : wsel == SEL_NONE ? RESP_SLVERR : RESP_OKAY;
    msip_d = (commit && wsel == SEL_MSIP && wstrb_d[0]) ? wdata_d[0] : msip_q;
    time_we = commit && wsel == SEL_MTIME;
    cmp_we = commit && wsel == SEL_MTIMECMP;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= R_IDLE;
      w_q <= W_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
      aw_q <= 1'b0;
      wh_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      msip_q <= 1'b0;
      cmsip_q <= 1'b0;
    end else begin
      r_q <= r_d;
      w_q <= w_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
      aw_q <= aw_d;
      wh_q <= wh_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      msip_q <= msip_d;
      cmsip_q <= msip_q;
    end
  end
  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .time_we(time_we),
    .cmp_we(cmp_we),
    .wmask(wmask),
    .wdata(wdata_d),
    .mtime(mtime),
    .mtimecmp(mtimecmp),
    .mtip(clint_mtip)
  );
endmodule

// File: tb/tb_clint_axi_lite.sv
// tb_clint_axi_lite: scoreboard bench for the CLINT AXI4-Lite responder
module tb_clint_axi_lite;
  localparam logic [31:0] B = 32'h0200_0000;
  localparam logic [31:0] A_MSIP = B;
  localparam logic [31:0] A_CMP = B + 32'h4000;
  localparam logic [31:0] A_TIME = B + 32'hBFF8;
  logic clk = 0, rst = 0;
  logic [31:0] AWADDR = 0, ARADDR = 0;
  logic AWVALID = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
  logic [63:0] WDATA = 0;
  logic [7:0] WSTRB = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, clint_mtip, clint_msip;
  logic [1:0] BRESP, RRESP;
  logic [63:0] RDATA;
  typedef struct packed {logic [63:0] d; logic [1:0] r;} rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];
  int checks = 0, failures = 0;
  logic [63:0] m = 0, mdl_val = 0;
  logic mdl_ld = 0;
  always #5 clk = ~clk;
  clint_axi_lite dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .clint_mtip(clint_mtip), .clint_msip(clint_msip)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) m <= !rst ? 64'd0 : mdl_ld ? mdl_val : m + 64'd1;
  always @(negedge clk) if (rst && RVALID && RREADY) begin
    rexp_t e;
    if (rq.size() == 0) chk("r_unexpected", 1, 0);
    else begin
      e = rq.pop_front();
      chk("rdata", RDATA, e.d);
      chk("rresp", 64'(RRESP), 64'(e.r));
    end
  end
  always @(negedge clk) if (rst && BVALID && BREADY) begin
    if (bq.size() == 0) chk("b_unexpected", 1, 0);
    else chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
  end
  task automatic rd(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r, input bit use_m);
    int n = 0;
    rexp_t e;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!ARREADY) chk("ar_timeout", 0, 1);
    ARADDR = a;
    ARVALID = 1;
    e.d = use_m ? m : d;
    e.r = r;
    rq.push_back(e);
    @(negedge clk);
    ARVALID = 0;
    chk("rvalid_lat", 64'(RVALID), 1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic [1:0] r);
    int n = 0;
    while (!(AWREADY && WREADY) && n < 50) begin @(negedge clk); n++; end
    if (!(AWREADY && WREADY)) chk("aw_timeout", 0, 1);
    AWADDR = a;
    WDATA = d;
    WSTRB = s;
    AWVALID = 1;
    WVALID = 1;
    bq.push_back(r);
    mdl_ld = a == A_TIME && s == 8'hFF;
    mdl_val = d;
    @(negedge clk);
    AWVALID = 0;
    WVALID = 0;
    mdl_ld = 0;
    chk("bvalid_lat", 64'(BVALID), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(ARREADY), 1);
    chk("rst_awready", 64'(AWREADY), 1);
    chk("rst_wready", 64'(WREADY), 1);
    chk("rst_rvalid", 64'(RVALID), 0);
    chk("rst_bvalid", 64'(BVALID), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_resps", 64'({RRESP, BRESP}), 0);
    chk("rst_mtip", 64'(clint_mtip), 0);
    chk("rst_msip", 64'(clint_msip), 0);
    rst = 1;
    repeat (10) @(negedge clk);
    rd(A_TIME, 0, 2'b00, 1);
    chk("mtip_idle", 64'(clint_mtip), 0);
    wr(A_CMP, 64'h1111_2222_3333_4444, 8'h0F, 2'b00);
    rd(A_CMP, 64'hFFFF_FFFF_3333_4444, 2'b00, 0);
    @(posedge clk); #1 BREADY = 0;
    @(negedge clk);
    wr(B + 32'h4004, 64'hDEAD_BEEF, 8'hFF, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 64'(BVALID), 1);
      chk("b_hold_resp", 64'(BRESP), 2);
      chk("b_hold_awready", 64'(AWREADY), 0);
    end
    @(posedge clk); #1 BREADY = 1;
    @(negedge clk);
    rd(A_CMP, 64'hFFFF_FFFF_3333_4444, 2'b00, 0);
    @(posedge clk); #1 RREADY = 0;
    @(negedge clk);
    rd(B + 32'h10, 0, 2'b10, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 64'(RVALID), 1);
      chk("r_hold_data", RDATA, 0);
      chk("r_hold_resp", 64'(RRESP), 2);
      chk("r_hold_arready", 64'(ARREADY), 0);
    end
    @(posedge clk); #1 RREADY = 1;
    @(negedge clk);
    rd(B + 32'h4004, 0, 2'b10, 0);
    rd(B + 32'hBFFC, 0, 2'b10, 0);
    wr(B + 32'h10, '1, 8'hFF, 2'b10);
    rd(A_MSIP, 0, 2'b00, 0);
    wr(A_CMP, 0, 8'h00, 2'b00);
    rd(A_CMP, 64'hFFFF_FFFF_3333_4444, 2'b00, 0);
    wr(A_TIME, 0, 8'hFF, 2'b00);
    rd(A_TIME, 0, 2'b00, 1);
    @(negedge clk);
    WDATA = 64'h20;
    WSTRB = 8'hFF;
    WVALID = 1;
    @(negedge clk);
    WVALID = 0;
    chk("w_first_wready", 64'(WREADY), 0);
    chk("w_first_awready", 64'(AWREADY), 1);
    chk("w_first_bvalid", 64'(BVALID), 0);
    AWADDR = A_CMP;
    AWVALID = 1;
    bq.push_back(2'b00);
    @(negedge clk);
    AWVALID = 0;
    chk("aw_second_bvalid", 64'(BVALID), 1);
    n = 0;
    while (m != 64'h20 && n < 200) begin @(negedge clk); n++; end
    chk("cmp_reach_timeout", 64'(n < 200), 1);
    chk("mtip_before", 64'(clint_mtip), 0);
    @(negedge clk);
    chk("mtip_rise", 64'(clint_mtip), 1);
    rd(A_TIME, 0, 2'b00, 1);
    wr(A_CMP, '1, 8'hFF, 2'b00);
    wr(A_TIME, '1, 8'hFF, 2'b00);
    chk("mtip_wrap_pre", 64'(clint_mtip), 0);
    @(negedge clk);
    chk("mtip_at_max", 64'(clint_mtip), 1);
    @(negedge clk);
    chk("mtip_after_wrap", 64'(clint_mtip), 0);
    rd(A_TIME, 0, 2'b00, 1);
    wr(A_MSIP, 64'hFFFF_0000_0000_0001, 8'hFF, 2'b00);
    @(negedge clk);
    chk("clint_msip_set", 64'(clint_msip), 1);
    rd(A_MSIP, 1, 2'b00, 0);
    wr(A_MSIP, 0, 8'hFE, 2'b00);
    rd(A_MSIP, 1, 2'b00, 0);
    @(negedge clk);
    ARADDR = A_CMP;
    ARVALID = 1;
    AWADDR = A_CMP;
    WDATA = 64'h5555;
    WSTRB = 8'hFF;
    AWVALID = 1;
    WVALID = 1;
    rq.push_back({64'hFFFF_FFFF_FFFF_FFFF, 2'b00});
    bq.push_back(2'b00);
    @(negedge clk);
    ARVALID = 0;
    AWVALID = 0;
    WVALID = 0;
    rd(A_CMP, 64'h5555, 2'b00, 0);
    @(posedge clk); #1 RREADY = 0;
    @(negedge clk);
    rd(A_MSIP, 1, 2'b00, 0);
    @(negedge clk);
    rst = 0;
    rq.delete();
    bq.delete();
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(RVALID), 0);
    chk("rst_mid_msip", 64'(clint_msip), 0);
    chk("rst_mid_arready", 64'(ARREADY), 1);
    RREADY = 1;
    rst = 1;
    rd(A_CMP, '1, 2'b00, 0);
    rd(A_MSIP, 0, 2'b00, 0);
    repeat (3) @(negedge clk);
    chk("rq_empty", 64'(rq.size()), 0);
    chk("bq_empty", 64'(bq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
